// File: rtl/ucsbece154b_fifo_push_arbiter_if.sv
// Push-side bundle between NR_REQ requesters, the arbiter and one FIFO.
// master: the arbiter's view. slave: the environment (requesters + FIFO).
interface ucsbece154b_fifo_push_arbiter_if #(
  parameter int NR_REQ     = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int ID_W = $clog2(NR_REQ);

  logic [NR_REQ-1:0]            req_valid_i;
  logic [NR_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NR_REQ-1:0]            req_ready_o;
  logic                         fifo_full_i;
  logic                         fifo_push_o;
  logic [DATA_WIDTH-1:0]        fifo_data_o;
  logic [ID_W-1:0]              fifo_id_o;

  modport master (
    input  req_valid_i, req_data_i, fifo_full_i,
    output req_ready_o, fifo_push_o, fifo_data_o, fifo_id_o
  );

  modport slave (
    output req_valid_i, req_data_i, fifo_full_i,
    input  req_ready_o, fifo_push_o, fifo_data_o, fifo_id_o
  );
endinterface

// File: rtl/ucsbece154b_fifo_push_arbiter.sv
// Round-robin push arbiter with burst locking in front of a single FIFO.
// The grant is combinational (zero-latency valid/ready); a winner keeps the
// grant for up to MAX_BURST pushes, and a dropped owner valid ends the burst
// with a single bubble cycle.
module ucsbece154b_fifo_push_arbiter #(
  parameter int NR_REQ     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  ucsbece154b_fifo_push_arbiter_if.master     bus,
  output logic                                busy_o,
  output logic [$clog2(NR_REQ)-1:0]           owner_o
);
  localparam int ID_W  = $clog2(NR_REQ);
  localparam int PW    = ID_W + 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  logic [ID_W-1:0]  grant_idx;
  logic             grant_vld;
  logic [PW-1:0]    probe;
  logic             xfer;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] i);
    if (i == ID_W'(NR_REQ - 1)) return '0;
    return i + ID_W'(1);
  endfunction

  // Grant selection: owner while bursting, else first valid from rr_ptr onward
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    probe     = '0;
    if (state_q == BURST) begin
      grant_idx = owner_q;
      grant_vld = bus.req_valid_i[owner_q];
    end else begin
      for (int k = 0; k < NR_REQ; k++) begin
        probe = {1'b0, rr_ptr_q} + PW'(k);
        if (probe >= PW'(NR_REQ)) probe = probe - PW'(NR_REQ);
        if (!grant_vld && bus.req_valid_i[probe[ID_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = probe[ID_W-1:0];
        end
      end
    end
  end

  // Handshake outputs; everything is forced quiet while rst_n is low
  assign bus.req_ready_o = (grant_vld && !bus.fifo_full_i && rst_n)
                           ? (NR_REQ'(1) << grant_idx) : '0;
  assign xfer            = |(bus.req_valid_i & bus.req_ready_o);
  assign bus.fifo_push_o = xfer;
  assign bus.fifo_data_o = xfer ? bus.req_data_i[grant_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.fifo_id_o   = xfer ? grant_idx : '0;
  assign busy_o          = rst_n && (state_q == BURST);
  assign owner_o         = owner_q;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state: burst entry, counting, and the two burst exits
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (MAX_BURST > 1) begin
            state_d = BURST;
            owner_d = grant_idx;
            cnt_d   = CNT_W'(1);
          end else begin
            rr_ptr_d = wrap_inc(grant_idx);
          end
        end
      end
      BURST: begin
        if (!bus.req_valid_i[owner_q]) begin
          state_d  = IDLE;
          cnt_d    = '0;
          rr_ptr_d = wrap_inc(owner_q);
        end else if (xfer) begin
          if (cnt_inc == CNT_W'(MAX_BURST)) begin
            state_d  = IDLE;
            cnt_d    = '0;
            rr_ptr_d = wrap_inc(owner_q);
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_ucsbece154b_fifo_push_arbiter.sv
// Bench for the FIFO push arbiter: MAX_BURST=4 and MAX_BURST=1 instances
// share clock, reset and stimulus; each scenario checks one of them.
module tb_ucsbece154b_fifo_push_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ucsbece154b_fifo_push_arbiter_if #(.NR_REQ(NR), .DATA_WIDTH(DW)) bus0 ();
  ucsbece154b_fifo_push_arbiter_if #(.NR_REQ(NR), .DATA_WIDTH(DW)) bus1 ();
  logic       busy0, busy1;
  logic [1:0] own0, own1;

  ucsbece154b_fifo_push_arbiter #(.NR_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) u_mb4 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .busy_o(busy0), .owner_o(own0));
  ucsbece154b_fifo_push_arbiter #(.NR_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(1)) u_mb1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .busy_o(busy1), .owner_o(own1));

  typedef struct packed {
    logic        push;
    logic [1:0]  id;
    logic [31:0] data;
    logic [3:0]  ready;
    logic        busy;
  } obs_t;

  typedef struct packed {
    obs_t       o;
    logic       chk_own;
    logic [1:0] own;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic [3:0] v;
    logic       full;
    logic       push;
    logic [1:0] id;
    logic       busy;
    logic [1:0] own;
  } row_t;

  exp_t        sb[$];
  obs_t        obs;
  logic [1:0]  obs_own;
  logic [31:0] pay[4];
  logic        prev_push = 1'b0;
  logic [1:0]  prev_id = 2'd0;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic row_t mk(int rst, int v, int full, int push, int id, int busy, int own);
    row_t r;
    r.rst  = rst[0];
    r.v    = v[3:0];
    r.full = full[0];
    r.push = push[0];
    r.id   = id[1:0];
    r.busy = busy[0];
    r.own  = own[1:0];
    return r;
  endfunction

  // Apply one cycle of stimulus to both instances, queue the expectation,
  // then sample the selected instance on the falling edge.
  task automatic drive(input row_t r, input bit sel);
    exp_t e;
    @(posedge clk);
    #1;
    if (prev_push) pay[prev_id] = $urandom;
    rst_n = r.rst;
    bus0.req_valid_i = r.v;
    bus1.req_valid_i = r.v;
    bus0.fifo_full_i = r.full;
    bus1.fifo_full_i = r.full;
    bus0.req_data_i  = {pay[3], pay[2], pay[1], pay[0]};
    bus1.req_data_i  = {pay[3], pay[2], pay[1], pay[0]};
    e.o.push  = r.push;
    e.o.id    = r.push ? r.id : 2'd0;
    e.o.data  = r.push ? pay[r.id] : 32'd0;
    e.o.ready = r.push ? (4'b0001 << r.id) : 4'b0000;
    e.o.busy  = r.busy;
    e.chk_own = r.busy || !r.rst;
    e.own     = r.rst ? r.own : 2'd0;
    sb.push_back(e);
    prev_push = r.push;
    prev_id   = r.id;
    @(negedge clk);
    if (sel) begin
      obs     = '{bus1.fifo_push_o, bus1.fifo_id_o, bus1.fifo_data_o, bus1.req_ready_o, busy1};
      obs_own = own1;
    end else begin
      obs     = '{bus0.fifo_push_o, bus0.fifo_id_o, bus0.fifo_data_o, bus0.req_ready_o, busy0};
      obs_own = own0;
    end
  endtask

  task automatic test_reset();
    row_t q[$];
    exp_t e;
    q.push_back(mk(0, 'b1111, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 'b0001, 0, 1, 0, 0, 0));
    q.push_back(mk(1, 'b0001, 0, 1, 0, 1, 0));
    q.push_back(mk(0, 'b0001, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 'b0101, 0, 1, 0, 0, 0));
    q.push_back(mk(1, 'b0101, 0, 1, 0, 1, 0));
    q.push_back(mk(1, 'b0101, 0, 1, 0, 1, 0));
    q.push_back(mk(1, 'b0101, 0, 1, 0, 1, 0));
    q.push_back(mk(1, 'b0101, 0, 1, 2, 0, 0));
    q.push_back(mk(1, 'b0001, 0, 0, 0, 1, 2));
    q.push_back(mk(1, 'b0001, 0, 1, 0, 0, 0));
    foreach (q[k]) begin
      drive(q[k], 1'b0);
      e = sb.pop_front();
      n_vec++;
      if (obs !== e.o) begin
        n_err++;
        $display("FAIL reset row %0d: got push/id/data/ready/busy %h, want %h", k, obs, e.o);
      end
      if (e.chk_own) begin
        n_vec++;
        if (obs_own !== e.own) begin
          n_err++;
          $display("FAIL reset owner row %0d: got %0d, want %0d", k, obs_own, e.own);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    row_t q[$];
    exp_t e;
    q.push_back(mk(0, 'b0000, 0, 0, 0, 0, 0));
    for (int i = 0; i < 17; i++)
      q.push_back(mk(1, 'b1111, 0, 1, (i / 4) % 4, int'(i % 4 != 0), (i / 4) % 4));
    foreach (q[k]) begin
      drive(q[k], 1'b0);
      e = sb.pop_front();
      n_vec++;
      if (obs !== e.o) begin
        n_err++;
        $display("FAIL round_robin row %0d: got %h, want %h", k, obs, e.o);
      end
      if (e.chk_own) begin
        n_vec++;
        if (obs_own !== e.own) begin
          n_err++;
          $display("FAIL round_robin owner row %0d: got %0d, want %0d", k, obs_own, e.own);
        end
      end
    end
  endtask

  task automatic test_valid_drop();
    row_t q[$];
    exp_t e;
    q.push_back(mk(0, 'b0000, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 'b1010, 0, 1, 1, 0, 0));
    q.push_back(mk(1, 'b1010, 0, 1, 1, 1, 1));
    q.push_back(mk(1, 'b1000, 0, 0, 0, 1, 1));
    q.push_back(mk(1, 'b1000, 0, 1, 3, 0, 0));
    q.push_back(mk(1, 'b0000, 0, 0, 0, 1, 3));
    q.push_back(mk(1, 'b0000, 0, 0, 0, 0, 0));
    foreach (q[k]) begin
      drive(q[k], 1'b0);
      e = sb.pop_front();
      n_vec++;
      if (obs !== e.o) begin
        n_err++;
        $display("FAIL valid_drop row %0d: got %h, want %h", k, obs, e.o);
      end
      if (e.chk_own) begin
        n_vec++;
        if (obs_own !== e.own) begin
          n_err++;
          $display("FAIL valid_drop owner row %0d: got %0d, want %0d", k, obs_own, e.own);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    row_t q[$];
    exp_t e;
    q.push_back(mk(0, 'b0000, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 'b0001, 1, 0, 0, 0, 0));
    q.push_back(mk(1, 'b0001, 0, 1, 0, 0, 0));
    q.push_back(mk(1, 'b0001, 0, 1, 0, 1, 0));
    for (int i = 0; i < 3; i++) q.push_back(mk(1, 'b0001, 1, 0, 0, 1, 0));
    q.push_back(mk(1, 'b0001, 0, 1, 0, 1, 0));
    q.push_back(mk(1, 'b0001, 0, 1, 0, 1, 0));
    q.push_back(mk(1, 'b0011, 0, 1, 1, 0, 0));
    q.push_back(mk(1, 'b0010, 1, 0, 0, 1, 1));
    q.push_back(mk(1, 'b0000, 1, 0, 0, 1, 1));
    q.push_back(mk(1, 'b0100, 0, 1, 2, 0, 0));
    foreach (q[k]) begin
      drive(q[k], 1'b0);
      e = sb.pop_front();
      n_vec++;
      if (obs !== e.o) begin
        n_err++;
        $display("FAIL full_stall row %0d: got %h, want %h", k, obs, e.o);
      end
      if (e.chk_own) begin
        n_vec++;
        if (obs_own !== e.own) begin
          n_err++;
          $display("FAIL full_stall owner row %0d: got %0d, want %0d", k, obs_own, e.own);
        end
      end
    end
  endtask

  task automatic test_wrap();
    row_t q[$];
    exp_t e;
    q.push_back(mk(0, 'b0000, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) q.push_back(mk(1, 'b0100, 0, 1, 2, int'(i != 0), 2));
    for (int i = 0; i < 4; i++) q.push_back(mk(1, 'b1001, 0, 1, 3, int'(i != 0), 3));
    q.push_back(mk(1, 'b1001, 0, 1, 0, 0, 0));
    q.push_back(mk(1, 'b0001, 0, 1, 0, 1, 0));
    foreach (q[k]) begin
      drive(q[k], 1'b0);
      e = sb.pop_front();
      n_vec++;
      if (obs !== e.o) begin
        n_err++;
        $display("FAIL wrap row %0d: got %h, want %h", k, obs, e.o);
      end
      if (e.chk_own) begin
        n_vec++;
        if (obs_own !== e.own) begin
          n_err++;
          $display("FAIL wrap owner row %0d: got %0d, want %0d", k, obs_own, e.own);
        end
      end
    end
  endtask

  task automatic test_max_burst1();
    row_t q[$];
    exp_t e;
    q.push_back(mk(0, 'b0000, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) q.push_back(mk(1, 'b0100, 0, 1, 2, 0, 0));
    for (int i = 0; i < 5; i++) q.push_back(mk(1, 'b1111, 0, 1, (i + 3) % 4, 0, 0));
    foreach (q[k]) begin
      drive(q[k], 1'b1);
      e = sb.pop_front();
      n_vec++;
      if (obs !== e.o) begin
        n_err++;
        $display("FAIL max_burst1 row %0d: got %h, want %h", k, obs, e.o);
      end
      if (e.chk_own) begin
        n_vec++;
        if (obs_own !== e.own) begin
          n_err++;
          $display("FAIL max_burst1 owner row %0d: got %0d, want %0d", k, obs_own, e.own);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus0.req_valid_i = '0;
    bus1.req_valid_i = '0;
    bus0.fifo_full_i = 1'b0;
    bus1.fifo_full_i = 1'b0;
    bus0.req_data_i  = '0;
    bus1.req_data_i  = '0;
    for (int i = 0; i < 4; i++) pay[i] = $urandom;
    test_reset();
    test_round_robin();
    test_valid_drop();
    test_full_stall();
    test_wrap();
    test_max_burst1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
